id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 261 ++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage for a MIPS subset: decode, operand select, hazard stall, branch resolve, ID/EX register.
// Build option ID_FORWARD_EN: forward EX/MEM results into operands instead of stalling on them.
module id_stage #(
  parameter int unsigned ALUOP_W    = 5,
  parameter int unsigned DELAY_SLOT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid_i,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        pc_i,
  output logic               id_ready_o,
  output logic [4:0]         readAddr1_o,
  output logic [4:0]         readAddr2_o,
  input  logic [31:0]        readData1_i,
  input  logic [31:0]        readData2_i,
  input  logic               ex_writeEnable_i,
  input  logic               ex_isLoad_i,
  input  logic [4:0]         ex_writeAddr_i,
  input  logic [31:0]        ex_writeData_i,
  input  logic               mem_writeEnable_i,
  input  logic [4:0]         mem_writeAddr_i,
  input  logic [31:0]        mem_writeData_i,
  input  logic               ex_ready_i,
  output logic               ex_valid_o,
  output logic               writeEnable_o,
  output logic               memRead_o,
  output logic               invalid_o,
  output logic [31:0]        oprand1_o,
  output logic [31:0]        oprand2_o,
  output logic [4:0]         writeAddr_o,
  output logic [ALUOP_W-1:0] ALUop_o,
  output logic               branchEnable_o,
  output logic [31:0]        branchAddr_o
);

  localparam logic [ALUOP_W-1:0] AluAnd = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AluOr  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AluXor = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AluNor = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] AluSll = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] AluSrl = ALUOP_W'(7);

  localparam logic [5:0] OpSpecial = 6'h00, OpBeq = 6'h04, OpBne = 6'h05, OpAddiu = 6'h09;
  localparam logic [5:0] OpAndi = 6'h0C, OpOri = 6'h0D, OpXori = 6'h0E, OpLui = 6'h0F;
  localparam logic [5:0] OpLw = 6'h23;
  localparam logic [5:0] FnSll = 6'h00, FnSrl = 6'h02, FnAddu = 6'h21, FnSubu = 6'h23;
  localparam logic [5:0] FnAnd = 6'h24, FnOr = 6'h25, FnXor = 6'h26, FnNor = 6'h27;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_zext, imm_sext;

  assign opcode   = inst_i[31:26];
  assign rs       = inst_i[25:21];
  assign rt       = inst_i[20:16];
  assign rd       = inst_i[15:11];
  assign shamt    = inst_i[10:6];
  assign funct    = inst_i[5:0];
  assign imm      = inst_i[15:0];
  assign imm_zext = {16'h0000, imm};
  assign imm_sext = {{16{imm[15]}}, imm};

  assign readAddr1_o = rs;
  assign readAddr2_o = rt;

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  assign ex_hit_rs  = ex_writeEnable_i && (rs != 5'd0) && (ex_writeAddr_i == rs);
  assign ex_hit_rt  = ex_writeEnable_i && (rt != 5'd0) && (ex_writeAddr_i == rt);
  assign mem_hit_rs = mem_writeEnable_i && (rs != 5'd0) && (mem_writeAddr_i == rs);
  assign mem_hit_rt = mem_writeEnable_i && (rt != 5'd0) && (mem_writeAddr_i == rt);

  logic [31:0] src1, src2;
`ifdef ID_FORWARD_EN
  // EX holds the younger result, so it wins over MEM.
  assign src1 = (rs == 5'd0) ? 32'd0 : ex_hit_rs ? ex_writeData_i :
                mem_hit_rs ? mem_writeData_i : readData1_i;
  assign src2 = (rt == 5'd0) ? 32'd0 : ex_hit_rt ? ex_writeData_i :
                mem_hit_rt ? mem_writeData_i : readData2_i;
`else
  logic unused_fwd_data;
  assign unused_fwd_data = ^{ex_writeData_i, mem_writeData_i};
  assign src1 = (rs == 5'd0) ? 32'd0 : readData1_i;
  assign src2 = (rt == 5'd0) ? 32'd0 : readData2_i;
`endif

  logic                dec_ok, use_rs, use_rt, dec_we, dec_mr, is_br, is_bne;
  logic [ALUOP_W-1:0]  dec_alu;
  logic [31:0]         dec_op1, dec_op2;
  logic [4:0]          dec_waddr;

  always_comb begin
    dec_ok    = 1'b1;
    use_rs    = 1'b1;
    use_rt    = 1'b0;
    dec_we    = 1'b1;
    dec_mr    = 1'b0;
    is_br     = 1'b0;
    is_bne    = 1'b0;
    dec_alu   = AluAnd;
    dec_op1   = src1;
    dec_op2   = src2;
    dec_waddr = rt;
    unique case (opcode)
      OpSpecial: begin
        use_rt    = 1'b1;
        dec_waddr = rd;
        unique case (funct)
          FnAnd:   dec_alu = AluAnd;
          FnOr:    dec_alu = AluOr;
          FnXor:   dec_alu = AluXor;
          FnNor:   dec_alu = AluNor;
          FnAddu:  dec_alu = AluAdd;
          FnSubu:  dec_alu = AluSub;
          FnSll, FnSrl: begin
            dec_alu = (funct == FnSll) ? AluSll : AluSrl;
            use_rs  = 1'b0;
            dec_op1 = {27'd0, shamt};
          end
          default: begin
            dec_ok = 1'b0;
            use_rs = 1'b0;
            use_rt = 1'b0;
            dec_we = 1'b0;
          end
        endcase
      end
      OpOri:   begin dec_alu = AluOr;  dec_op2 = imm_zext; end
      OpAndi:  begin dec_alu = AluAnd; dec_op2 = imm_zext; end
      OpXori:  begin dec_alu = AluXor; dec_op2 = imm_zext; end
      OpAddiu: begin dec_alu = AluAdd; dec_op2 = imm_sext; end
      OpLw:    begin dec_alu = AluAdd; dec_op2 = imm_sext; dec_mr = 1'b1; end
      OpLui: begin
        use_rs  = 1'b0;
        dec_alu = AluOr;
        dec_op1 = 32'd0;
        dec_op2 = {imm, 16'h0000};
      end
      OpBeq, OpBne: begin
        use_rt = 1'b1;
        dec_we = 1'b0;
        is_br  = 1'b1;
        is_bne = (opcode == OpBne);
      end
      default: begin
        dec_ok = 1'b0;
        use_rs = 1'b0;
        dec_we = 1'b0;
      end
    endcase
  end

  logic load_hit, hazard, advance, accept, taken;
  logic [31:0] br_target;

  assign load_hit = ex_isLoad_i && ((use_rs && ex_hit_rs) || (use_rt && ex_hit_rt));
`ifdef ID_FORWARD_EN
  assign hazard = load_hit;
`else
  assign hazard = load_hit || (use_rs && (ex_hit_rs || mem_hit_rs)) ||
                  (use_rt && (ex_hit_rt || mem_hit_rt));
`endif

  logic                ex_valid_q, ex_valid_d, we_q, we_d, mr_q, mr_d, inv_q, inv_d;
  logic                br_en_q, br_en_d, squash_q, squash_d;
  logic [31:0]         op1_q, op1_d, op2_q, op2_d, br_addr_q, br_addr_d;
  logic [4:0]          waddr_q, waddr_d;
  logic [ALUOP_W-1:0]  alu_q, alu_d;

  assign advance    = ex_ready_i || !ex_valid_q;
  assign id_ready_o = advance && !hazard && !rst;
  assign accept     = if_valid_i && id_ready_o;
  assign taken      = is_bne ? (src1 != src2) : (src1 == src2);
  assign br_target  = pc_i + 32'd4 + {imm_sext[29:0], 2'b00};

  always_comb begin
    ex_valid_d = ex_valid_q;
    we_d       = we_q;
    mr_d       = mr_q;
    inv_d      = inv_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    waddr_d    = waddr_q;
    alu_d      = alu_q;
    br_en_d    = 1'b0;
    br_addr_d  = br_addr_q;
    squash_d   = squash_q;
    if (advance) begin
      ex_valid_d = 1'b0;
      we_d       = 1'b0;
      mr_d       = 1'b0;
      inv_d      = 1'b0;
      op1_d      = 32'd0;
      op2_d      = 32'd0;
      waddr_d    = 5'd0;
      alu_d      = AluAnd;
      if (accept) begin
        if (squash_q) begin
          squash_d = 1'b0;
        end else if (is_br) begin
          br_en_d   = taken;
          br_addr_d = br_target;
          squash_d  = taken && (DELAY_SLOT == 0);
        end else if (!dec_ok) begin
          inv_d = 1'b1;
        end else begin
          ex_valid_d = 1'b1;
          we_d       = dec_we;
          mr_d       = dec_mr;
          op1_d      = dec_op1;
          op2_d      = dec_op2;
          waddr_d    = dec_waddr;
          alu_d      = dec_alu;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      we_q       <= 1'b0;
      mr_q       <= 1'b0;
      inv_q      <= 1'b0;
      op1_q      <= 32'd0;
      op2_q      <= 32'd0;
      waddr_q    <= 5'd0;
      alu_q      <= '0;
      br_en_q    <= 1'b0;
      br_addr_q  <= 32'd0;
      squash_q   <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      we_q       <= we_d;
      mr_q       <= mr_d;
      inv_q      <= inv_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      waddr_q    <= waddr_d;
      alu_q      <= alu_d;
      br_en_q    <= br_en_d;
      br_addr_q  <= br_addr_d;
      squash_q   <= squash_d;
    end
  end

  assign ex_valid_o     = ex_valid_q;
  assign writeEnable_o  = we_q;
  assign memRead_o      = mr_q;
  assign invalid_o      = inv_q;
  assign oprand1_o      = op1_q;
  assign oprand2_o      = op2_q;
  assign writeAddr_o    = waddr_q;
  assign ALUop_o        = alu_q;
  assign branchEnable_o = br_en_q;
  assign branchAddr_o   = br_addr_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage (DELAY_SLOT=0): decode vector table through a scoreboard plus hand-written
// hazard, forwarding, branch/squash, stall and reset sequences.
module tb_id_stage;
  localparam logic [4:0] AAnd = 5'd0, AOr = 5'd1, AXor = 5'd2, ANor = 5'd3;
  localparam logic [4:0] AAdd = 5'd4, ASub = 5'd5, ASll = 5'd6, ASrl = 5'd7;
  // {valid, we, memRead, invalid, branchEnable}
  localparam logic [4:0] FOk = 5'b11000, FLd = 5'b11100, FInv = 5'b00010, FBub = 5'b00000;
  localparam int NumVec = 16;

  logic        clk = 1'b0;
  logic        rst, if_valid_i, id_ready_o;
  logic [31:0] inst_i, pc_i, readData1_i, readData2_i;
  logic [4:0]  readAddr1_o, readAddr2_o;
  logic        ex_writeEnable_i, ex_isLoad_i, mem_writeEnable_i, ex_ready_i;
  logic [4:0]  ex_writeAddr_i, mem_writeAddr_i;
  logic [31:0] ex_writeData_i, mem_writeData_i;
  logic        ex_valid_o, writeEnable_o, memRead_o, invalid_o, branchEnable_o;
  logic [31:0] oprand1_o, oprand2_o, branchAddr_o;
  logic [4:0]  writeAddr_o, ALUop_o;

  always #5 clk = ~clk;

  id_stage #(.ALUOP_W(5), .DELAY_SLOT(0)) dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .inst_i(inst_i), .pc_i(pc_i),
    .id_ready_o(id_ready_o), .readAddr1_o(readAddr1_o), .readAddr2_o(readAddr2_o),
    .readData1_i(readData1_i), .readData2_i(readData2_i),
    .ex_writeEnable_i(ex_writeEnable_i), .ex_isLoad_i(ex_isLoad_i),
    .ex_writeAddr_i(ex_writeAddr_i), .ex_writeData_i(ex_writeData_i),
    .mem_writeEnable_i(mem_writeEnable_i), .mem_writeAddr_i(mem_writeAddr_i),
    .mem_writeData_i(mem_writeData_i), .ex_ready_i(ex_ready_i),
    .ex_valid_o(ex_valid_o), .writeEnable_o(writeEnable_o), .memRead_o(memRead_o),
    .invalid_o(invalid_o), .oprand1_o(oprand1_o), .oprand2_o(oprand2_o),
    .writeAddr_o(writeAddr_o), .ALUop_o(ALUop_o), .branchEnable_o(branchEnable_o),
    .branchAddr_o(branchAddr_o)
  );

  typedef struct packed {
    logic [31:0] inst, rf1, rf2;
    logic        valid, we, mr, inv, br;
    logic [31:0] op1, op2;
    logic [4:0]  waddr, alu;
  } vec_t;

  vec_t vecs [NumVec];
  vec_t sb [$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mk(input logic [31:0] inst, rf1, rf2, input logic [4:0] fl,
                              input logic [31:0] op1, op2, input logic [4:0] waddr, alu);
    vec_t v;
    v.inst = inst; v.rf1 = rf1; v.rf2 = rf2;
    v.valid = fl[4]; v.we = fl[3]; v.mr = fl[2]; v.inv = fl[1]; v.br = fl[0];
    v.op1 = op1; v.op2 = op2; v.waddr = waddr; v.alu = alu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, pc, rf1, rf2);
    if_valid_i = 1'b1; inst_i = inst; pc_i = pc; readData1_i = rf1; readData2_i = rf2;
    #1;
  endtask

  task automatic clear_fwd();
    ex_writeEnable_i = 1'b0; ex_isLoad_i = 1'b0; ex_writeAddr_i = 5'd0; ex_writeData_i = 32'd0;
    mem_writeEnable_i = 1'b0; mem_writeAddr_i = 5'd0; mem_writeData_i = 32'd0;
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ex_valid"}, ex_valid_o, 32'd0);
    chk({tag, ".we"}, writeEnable_o, 32'd0);
    chk({tag, ".mr"}, memRead_o, 32'd0);
    chk({tag, ".inv"}, invalid_o, 32'd0);
    chk({tag, ".br_en"}, branchEnable_o, 32'd0);
    chk({tag, ".br_addr"}, branchAddr_o, 32'd0);
    chk({tag, ".op1"}, oprand1_o, 32'd0);
    chk({tag, ".op2"}, oprand2_o, 32'd0);
    chk({tag, ".waddr"}, writeAddr_o, 32'd0);
    chk({tag, ".alu"}, ALUop_o, 32'd0);
  endtask

  initial begin
    vec_t e;
    vecs[0]  = mk(itype(6'h0D, 0, 1, 16'h00FF), 32'hDEADBEEF, 0, FOk, 0, 32'hFF, 1, AOr);
    vecs[1]  = mk(rtype(1, 2, 3, 0, 6'h21), 32'h10, 32'h20, FOk, 32'h10, 32'h20, 3, AAdd);
    vecs[2]  = mk(rtype(5, 6, 4, 0, 6'h23), 7, 3, FOk, 7, 3, 4, ASub);
    vecs[3]  = mk(rtype(8, 9, 7, 0, 6'h27), 32'hA5A5, 32'h0F0F, FOk, 32'hA5A5, 32'h0F0F, 7, ANor);
    vecs[4]  = mk(rtype(2, 3, 1, 0, 6'h26), 1, 2, FOk, 1, 2, 1, AXor);
    vecs[5]  = mk(rtype(0, 11, 10, 5, 6'h00), 32'h999, 3, FOk, 5, 3, 10, ASll);
    vecs[6]  = mk(rtype(0, 13, 12, 31, 6'h02), 0, 32'h80000000, FOk, 31, 32'h80000000, 12, ASrl);
    vecs[7]  = mk(itype(6'h0C, 15, 14, 16'h8001), 32'hFFFF, 0, FOk, 32'hFFFF, 32'h8001, 14, AAnd);
    vecs[8]  = mk(itype(6'h0E, 17, 16, 16'hFFFF), 32'h1234, 0, FOk, 32'h1234, 32'hFFFF, 16, AXor);
    vecs[9]  = mk(itype(6'h09, 19, 18, 16'hFFFE), 100, 0, FOk, 100, 32'hFFFFFFFE, 18, AAdd);
    vecs[10] = mk(itype(6'h23, 21, 20, 16'h0010), 32'h1000, 0, FLd, 32'h1000, 32'h10, 20, AAdd);
    vecs[11] = mk(itype(6'h0F, 0, 22, 16'hABCD), 32'h1111, 0, FOk, 0, 32'hABCD0000, 22, AOr);
    vecs[12] = mk(itype(6'h3F, 1, 2, 16'h1234), 1, 2, FInv, 0, 0, 0, 0);
    vecs[13] = mk(rtype(1, 2, 3, 0, 6'h3F), 1, 2, FInv, 0, 0, 0, 0);
    vecs[14] = mk(itype(6'h05, 1, 2, 16'h0004), 5, 5, FBub, 0, 0, 0, 0);
    vecs[15] = mk(rtype(2, 0, 3, 0, 6'h25), 32'h77, 32'h55, FOk, 32'h77, 0, 3, AOr);

    // Reset with an instruction presented: it must be discarded.
    rst = 1'b1; ex_ready_i = 1'b1;
    clear_fwd();
    drive(itype(6'h0D, 0, 9, 16'h0042), 32'h0, 0, 0);
    tick(); tick();
    chk("rst.id_ready", id_ready_o, 0);
    chk_zero("rst");

    // First accept right after reset release.
    rst = 1'b0;
    drive(itype(6'h0D, 0, 1, 16'h00FF), 32'h0, 0, 0);
    chk("ori.id_ready", id_ready_o, 1);
    tick();
    chk("ori.ex_valid", ex_valid_o, 1);
    chk("ori.op1", oprand1_o, 0);
    chk("ori.op2", oprand2_o, 32'hFF);
    chk("ori.waddr", writeAddr_o, 1);
    chk("ori.alu", ALUop_o, AOr);

    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].inst, 32'h200 + 32'(i * 4), vecs[i].rf1, vecs[i].rf2);
      chk($sformatf("v%0d.id_ready", i), id_ready_o, 1);
      sb.push_back(vecs[i]);
      tick();
      e = sb.pop_front();
      chk($sformatf("v%0d.ex_valid", i), ex_valid_o, e.valid);
      chk($sformatf("v%0d.we", i), writeEnable_o, e.we);
      chk($sformatf("v%0d.mr", i), memRead_o, e.mr);
      chk($sformatf("v%0d.inv", i), invalid_o, e.inv);
      chk($sformatf("v%0d.br_en", i), branchEnable_o, e.br);
      if (e.valid) begin
        chk($sformatf("v%0d.op1", i), oprand1_o, e.op1);
        chk($sformatf("v%0d.op2", i), oprand2_o, e.op2);
        chk($sformatf("v%0d.waddr", i), writeAddr_o, e.waddr);
        chk($sformatf("v%0d.alu", i), ALUop_o, e.alu);
      end
    end

    // EX and MEM both writing $2, or $3,$2,$0.
    ex_writeEnable_i = 1'b1; ex_writeAddr_i = 5'd2; ex_writeData_i = 32'h1234;
    mem_writeEnable_i = 1'b1; mem_writeAddr_i = 5'd2; mem_writeData_i = 32'h5678;
    drive(rtype(2, 0, 3, 0, 6'h25), 32'h300, 32'hAAAA, 0);
    chk("fwd.raddr1", readAddr1_o, 2);
`ifdef ID_FORWARD_EN
    chk("fwd.id_ready", id_ready_o, 1);
    tick();
    chk("fwd.ex_op1", oprand1_o, 32'h1234);
    ex_writeEnable_i = 1'b0;
    #1;
    tick();
    chk("fwd.mem_op1", oprand1_o, 32'h5678);
`else
    chk("raw.id_ready_both", id_ready_o, 0);
    tick();
    chk("raw.bubble", ex_valid_o, 0);
    ex_writeEnable_i = 1'b0;
    #1;
    chk("raw.id_ready_mem", id_ready_o, 0);
    tick();
    mem_writeEnable_i = 1'b0;
    #1;
    chk("raw.id_ready_clear", id_ready_o, 1);
    tick();
    chk("raw.ex_valid", ex_valid_o, 1);
    chk("raw.op1", oprand1_o, 32'hAAAA);
`endif
    clear_fwd();

    // Load-use on $4: one stall cycle with a bubble, then accepted.
    ex_writeEnable_i = 1'b1; ex_isLoad_i = 1'b1; ex_writeAddr_i = 5'd4;
    drive(rtype(4, 4, 5, 0, 6'h24), 32'h304, 3, 3);
    chk("lu.id_ready", id_ready_o, 0);
    tick();
    chk("lu.bubble", ex_valid_o, 0);
    chk("lu.bubble_we", writeEnable_o, 0);
    clear_fwd();
    chk("lu.id_ready_after", id_ready_o, 1);
    tick();
    chk("lu.ex_valid", ex_valid_o, 1);
    chk("lu.waddr", writeAddr_o, 5);
    chk("lu.alu", ALUop_o, AAnd);
    // rt of an I-type is a destination, not a source; $0 never matches.
    ex_writeEnable_i = 1'b1; ex_isLoad_i = 1'b1; ex_writeAddr_i = 5'd4;
    drive(itype(6'h0D, 0, 4, 16'h0005), 32'h308, 0, 0);
    chk("lu.unused_rt", id_ready_o, 1);
    ex_writeAddr_i = 5'd0;
    drive(rtype(0, 0, 3, 0, 6'h25), 32'h30C, 0, 0);
    chk("lu.reg0", id_ready_o, 1);
    tick();
    clear_fwd();

    // Taken beq at 0x100, squash survives a stall, then clears.
    drive(itype(6'h04, 1, 1, 16'h0003), 32'h100, 7, 7);
    chk("beq.id_ready", id_ready_o, 1);
    tick();
    chk("beq.br_en", branchEnable_o, 1);
    chk("beq.br_addr", branchAddr_o, 32'h110);
    chk("beq.ex_valid", ex_valid_o, 0);
    ex_writeEnable_i = 1'b1; ex_isLoad_i = 1'b1; ex_writeAddr_i = 5'd9;
    drive(itype(6'h0D, 9, 10, 16'h0001), 32'h104, 32'h40, 0);
    chk("sq.stall", id_ready_o, 0);
    tick();
    chk("beq.pulse_end", branchEnable_o, 0);
    clear_fwd();
    chk("sq.id_ready", id_ready_o, 1);
    tick();
    chk("sq.squashed", ex_valid_o, 0);
    chk("sq.squashed_we", writeEnable_o, 0);
    drive(itype(6'h0D, 9, 10, 16'h0001), 32'h108, 32'h40, 0);
    tick();
    chk("sq.next_valid", ex_valid_o, 1);
    chk("sq.next_op1", oprand1_o, 32'h40);

    // Backward bne from address 0 wraps the target.
    drive(itype(6'h05, 1, 2, 16'hFFFE), 32'h0, 1, 2);
    tick();
    chk("bne.br_en", branchEnable_o, 1);
    chk("bne.br_addr", branchAddr_o, 32'hFFFFFFFC);
    drive(itype(6'h0D, 0, 11, 16'h0001), 32'h4, 0, 0);
    tick();
    chk("bne.squashed", ex_valid_o, 0);

    // Back-pressure holds the output register; reset mid-stall clears it.
    drive(itype(6'h0D, 0, 1, 16'h00FF), 32'h400, 0, 0);
    tick();
    chk("st.ex_valid", ex_valid_o, 1);
    ex_ready_i = 1'b0;
    drive(itype(6'h0E, 0, 2, 16'h0001), 32'h404, 0, 0);
    chk("st.id_ready", id_ready_o, 0);
    tick();
    chk("st.hold_valid", ex_valid_o, 1);
    chk("st.hold_op2", oprand2_o, 32'hFF);
    chk("st.hold_waddr", writeAddr_o, 1);
    chk("st.hold_alu", ALUop_o, AOr);
    rst = 1'b1;
    #1;
    chk("st.rst_ready", id_ready_o, 0);
    tick();
    chk_zero("st.rst");
    rst = 1'b0; ex_ready_i = 1'b1;
    #1;
    chk("st.post_ready", id_ready_o, 1);
    tick();
    chk("st.post_valid", ex_valid_o, 1);
    chk("st.post_waddr", writeAddr_o, 2);
    chk("st.post_alu", ALUop_o, AXor);

    // No instruction offered: a bubble goes out.
    if_valid_i = 1'b0;
    tick();
    chk("idle.bubble", ex_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
